// File: rtl/uart_word_bridge.sv
// uart_word_bridge
//   Word-level adapter on the parallel side of a UART.
//   RX path: packs received bytes (little-endian, first byte -> word[DATA_WIDTH-1:0])
//            into WORD_WIDTH-bit words presented with a valid/ready handshake.
//   TX path: accepts a WORD_WIDTH-bit word and feeds it byte by byte (little-endian)
//            to the UART transmitter, pacing on its available/done outputs.
//   The two paths share only clock and reset.
//
// Ports:
//   i_clock, i_reset                 clock, asynchronous active-low reset
//   i_rx_done, i_rx_data, i_rx_clear received byte strobe/data, partial-word discard
//   o_word, o_word_valid, i_word_ready  assembled word handshake
//   o_rx_count, o_rx_overrun         bytes in partial word, sticky dropped-word flag
//   i_tx_word, i_tx_word_valid, o_tx_word_ready  word-to-send handshake
//   o_tx_signal, o_tx_result         start pulse and byte to the UART transmitter
//   i_tx_available, i_tx_done        transmitter ready / byte-finished pulse
//   o_tx_busy                        word transmission in progress
//   o_tx_state                       debug view of the TX state register
//
// Handshakes: a word moves on a clock edge where valid and ready are both high.
// Once valid is raised its data is held stable until that edge. o_tx_word_ready
// is registered and depends only on the TX state, never on i_tx_word_valid.
module uart_word_bridge #(
    parameter  int DATA_WIDTH = 8,
    parameter  int WORD_WIDTH = 32,
    localparam int WORD_BYTES = WORD_WIDTH / DATA_WIDTH,
    localparam int CW         = $clog2(WORD_BYTES)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_clear,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic [CW-1:0]         o_rx_count,
    output logic                  o_rx_overrun,
    input  logic [WORD_WIDTH-1:0] i_tx_word,
    input  logic                  i_tx_word_valid,
    output logic                  o_tx_word_ready,
    output logic                  o_tx_signal,
    output logic [DATA_WIDTH-1:0] o_tx_result,
    input  logic                  i_tx_available,
    input  logic                  i_tx_done,
    output logic                  o_tx_busy,
    output logic [1:0]            o_tx_state
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

    // ------------------------------------------------------------------
    // RX: byte assembly
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] asm_q;
    logic [WORD_WIDTH-1:0] asm_next;
    logic                  rx_take;
    logic                  rx_last;

    // Clear beats a coincident byte strobe; that byte is thrown away.
    assign rx_take = i_rx_done && !i_rx_clear;
    assign rx_last = rx_take && (o_rx_count == LAST_IDX);

    // Assembly register with the incoming byte merged into its slot, so a
    // completing word can be handed to o_word in the same edge.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (o_rx_count == CW'(k)) begin
                asm_next[k*DATA_WIDTH +: DATA_WIDTH] = i_rx_data;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            asm_q        <= '0;
            o_rx_count   <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_rx_overrun <= 1'b0;
        end else begin
            if (i_rx_clear) begin
                o_rx_count <= '0;
                asm_q      <= '0;
            end else if (i_rx_done) begin
                asm_q      <= asm_next;
                o_rx_count <= rx_last ? '0 : o_rx_count + CW'(1);
            end

            // A completed word may replace the held one only if that one is
            // leaving on this same edge; otherwise it is dropped.
            if (rx_last) begin
                if (!o_word_valid || i_word_ready) begin
                    o_word       <= asm_next;
                    o_word_valid <= 1'b1;
                end else begin
                    o_rx_overrun <= 1'b1;
                end
            end else if (o_word_valid && i_word_ready) begin
                o_word_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX: word serializer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    tx_state_t             tx_state;
    tx_state_t             tx_state_next;
    logic [WORD_WIDTH-1:0] tx_buf;
    logic [CW-1:0]         tx_idx;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  tx_accept;
    logic                  tx_fire;
    logic                  tx_advance;

    assign o_tx_state = tx_state;

    always_comb begin
        tx_byte = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (tx_idx == CW'(k)) begin
                tx_byte = tx_buf[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_accept     = 1'b0;
        tx_fire       = 1'b0;
        tx_advance    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (i_tx_word_valid) begin
                    tx_accept     = 1'b1;
                    tx_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (i_tx_available) begin
                    tx_fire       = 1'b1;
                    tx_state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (tx_idx == LAST_IDX) begin
                        tx_state_next = TX_IDLE;
                    end else begin
                        tx_advance    = 1'b1;
                        tx_state_next = TX_SEND;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Ready/busy are registered from the next state so they change in the
    // same cycle the FSM enters or leaves TX_IDLE.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_state        <= TX_IDLE;
            tx_buf          <= '0;
            tx_idx          <= '0;
            o_tx_signal     <= 1'b0;
            o_tx_result     <= '0;
            o_tx_word_ready <= 1'b1;
            o_tx_busy       <= 1'b0;
        end else begin
            tx_state        <= tx_state_next;
            o_tx_signal     <= tx_fire;
            o_tx_word_ready <= (tx_state_next == TX_IDLE);
            o_tx_busy       <= (tx_state_next != TX_IDLE);
            if (tx_accept) begin
                tx_buf <= i_tx_word;
                tx_idx <= '0;
            end
            if (tx_advance) begin
                tx_idx <= tx_idx + CW'(1);
            end
            if (tx_fire) begin
                o_tx_result <= tx_byte;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_bridge.sv
`timescale 1ns/1ps
module tb_uart_word_bridge;

    localparam int DW = 8;
    localparam int WW = 32;
    localparam int WB = WW / DW;
    localparam int CW = $clog2(WB);

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic          i_rx_done       = 1'b0;
    logic [DW-1:0] i_rx_data       = '0;
    logic          i_rx_clear      = 1'b0;
    logic          i_word_ready    = 1'b0;
    logic [WW-1:0] i_tx_word       = '0;
    logic          i_tx_word_valid = 1'b0;
    logic          i_tx_available  = 1'b0;
    logic          i_tx_done       = 1'b0;
    logic [WW-1:0] o_word;
    logic          o_word_valid;
    logic [CW-1:0] o_rx_count;
    logic          o_rx_overrun;
    logic          o_tx_word_ready;
    logic          o_tx_signal;
    logic [DW-1:0] o_tx_result;
    logic          o_tx_busy;
    logic [1:0]    o_tx_state;

    uart_word_bridge #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx_done       (i_rx_done),
        .i_rx_data       (i_rx_data),
        .i_rx_clear      (i_rx_clear),
        .o_word          (o_word),
        .o_word_valid    (o_word_valid),
        .i_word_ready    (i_word_ready),
        .o_rx_count      (o_rx_count),
        .o_rx_overrun    (o_rx_overrun),
        .i_tx_word       (i_tx_word),
        .i_tx_word_valid (i_tx_word_valid),
        .o_tx_word_ready (o_tx_word_ready),
        .o_tx_signal     (o_tx_signal),
        .o_tx_result     (o_tx_result),
        .i_tx_available  (i_tx_available),
        .i_tx_done       (i_tx_done),
        .o_tx_busy       (o_tx_busy),
        .o_tx_state      (o_tx_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];      // bytes the transmitter should see, in order
    logic [DW-1:0] cap_q[$];      // bytes the transmitter model captured
    int            sig_cyc_q[$];  // cycle of each o_tx_signal pulse
    int            n_sig      = 0;
    int            done_delay = 10;  // 0 selects a random 1..5 cycle delay
    int            countdown  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART transmitter model: captures each start pulse and answers with a
    // one-cycle done pulse done_delay cycles later.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            countdown = -1;
            i_tx_done = 1'b0;
        end else begin
            i_tx_done = 1'b0;
            if (countdown == 0) begin
                i_tx_done = 1'b1;
                countdown = -1;
            end else if (countdown > 0) begin
                countdown--;
            end
            if (o_tx_signal) begin
                cap_q.push_back(o_tx_result);
                sig_cyc_q.push_back(cyc);
                n_sig++;
                countdown = ((done_delay > 0) ? done_delay : int'($urandom_range(1, 5))) - 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic send_word(input logic [WW-1:0] w, output int acc);
        acc             = -1;
        i_tx_word       = w;
        i_tx_word_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            if (o_tx_word_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        check("tx word accepted", (acc >= 0), 1);
        tick();
        i_tx_word_valid = 1'b0;
        if (acc >= 0) begin
            for (int b = 0; b < WB; b++) exp_q.push_back(w[b*DW +: DW]);
        end
    endtask

    task automatic wait_tx_idle(output int idle_cyc);
        idle_cyc = -1;
        for (int k = 0; k < 3000; k++) begin
            if (o_tx_word_ready && !o_tx_busy) begin
                idle_cyc = cyc;
                break;
            end
            tick();
        end
        check("tx returns idle", (idle_cyc >= 0), 1);
    endtask

    task automatic check_tx_bytes(input string name);
        check({name, " count"}, cap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            check(name, cap_q.pop_front(), exp_q.pop_front());
        end
        cap_q.delete();
        exp_q.delete();
        sig_cyc_q.delete();
        n_sig = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " o_word"}, o_word, 0);
        check({tag, " o_word_valid"}, o_word_valid, 0);
        check({tag, " o_rx_count"}, o_rx_count, 0);
        check({tag, " o_rx_overrun"}, o_rx_overrun, 0);
        check({tag, " o_tx_word_ready"}, o_tx_word_ready, 1);
        check({tag, " o_tx_signal"}, o_tx_signal, 0);
        check({tag, " o_tx_result"}, o_tx_result, 0);
        check({tag, " o_tx_busy"}, o_tx_busy, 0);
    endtask

    task automatic feed_byte(input logic [DW-1:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        tick();
        i_rx_done = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // RX vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          done;
        logic          clear;
        logic [DW-1:0] data;
        logic          ready;
        logic [CW-1:0] count;
        logic          valid;
        logic [WW-1:0] word;
        logic          ovr;
    } rx_vec_t;

    rx_vec_t vecs[$];

    task automatic add_vec(input logic d, input logic c, input logic [DW-1:0] b, input logic r,
                           input logic [CW-1:0] n, input logic v, input logic [WW-1:0] w,
                           input logic o);
        rx_vec_t e;
        e.done = d; e.clear = c; e.data = b; e.ready = r;
        e.count = n; e.valid = v; e.word = w; e.ovr = o;
        vecs.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Randomized phases with behavioural reference models
    // ------------------------------------------------------------------
    task automatic rx_random();
        logic [DW-1:0] m_bytes[$];
        logic [WW-1:0] m_word  = '0;
        logic [WW-1:0] w;
        logic          m_valid = 1'b0;
        logic          m_ovr   = 1'b0;
        logic          completed;
        for (int i = 0; i < 400; i++) begin
            i_rx_done    = ($urandom_range(0, 1) == 1);
            i_rx_data    = DW'($urandom);
            i_rx_clear   = ($urandom_range(0, 15) == 0);
            i_word_ready = ($urandom_range(0, 2) == 0);
            completed    = 1'b0;
            if (i_rx_clear) begin
                m_bytes.delete();
            end else if (i_rx_done) begin
                m_bytes.push_back(i_rx_data);
                if (m_bytes.size() == WB) begin
                    w = '0;
                    for (int b = 0; b < WB; b++) w[b*DW +: DW] = m_bytes[b];
                    m_bytes.delete();
                    completed = 1'b1;
                    if (!m_valid || i_word_ready) begin
                        m_word  = w;
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
            if (!completed && m_valid && i_word_ready) m_valid = 1'b0;
            tick();
            check("rx rand count", o_rx_count, m_bytes.size());
            check("rx rand valid", o_word_valid, m_valid);
            check("rx rand word", o_word, m_word);
            check("rx rand overrun", o_rx_overrun, m_ovr);
        end
        i_rx_done    = 1'b0;
        i_rx_clear   = 1'b0;
        i_word_ready = 1'b0;
    endtask

    task automatic tx_random();
        int   sent = 0;
        int   idle;
        logic acc_now;
        i_tx_word       = $urandom;
        i_tx_word_valid = 1'b1;
        for (int k = 0; k < 6000 && sent < 12; k++) begin
            i_tx_available = ($urandom_range(0, 3) != 0);
            acc_now = i_tx_word_valid && o_tx_word_ready;
            if (acc_now) begin
                for (int b = 0; b < WB; b++) exp_q.push_back(i_tx_word[b*DW +: DW]);
                sent++;
            end
            tick();
            if (acc_now) begin
                i_tx_word_valid = ($urandom_range(0, 1) == 1);
                i_tx_word       = $urandom;
            end else if (!i_tx_word_valid) begin
                i_tx_word_valid = ($urandom_range(0, 1) == 1);
            end
        end
        i_tx_word_valid = 1'b0;
        i_tx_available  = 1'b1;
        check("tx rand words accepted", sent, 12);
        wait_tx_idle(idle);
        check_tx_bytes("tx rand byte");
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int         acc;
        int         idle;
        int         r;
        logic [1:0] idle_state;

        #1 rst_n = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        idle_state = o_tx_state;
        #2 rst_n = 1'b1;
        tick();

        // RX assembly, overrun, back-to-back handoff and clear
        add_vec(1'b1, 1'b0, 8'h11, 1'b0, 2'd1, 1'b0, 32'h00000000, 1'b0);
        add_vec(1'b1, 1'b0, 8'h22, 1'b0, 2'd2, 1'b0, 32'h00000000, 1'b0);
        add_vec(1'b1, 1'b0, 8'h33, 1'b0, 2'd3, 1'b0, 32'h00000000, 1'b0);
        add_vec(1'b1, 1'b0, 8'h44, 1'b0, 2'd0, 1'b1, 32'h44332211, 1'b0);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 32'h44332211, 1'b0);
        add_vec(1'b1, 1'b0, 8'h01, 1'b0, 2'd1, 1'b0, 32'h44332211, 1'b0);
        add_vec(1'b1, 1'b0, 8'h02, 1'b0, 2'd2, 1'b0, 32'h44332211, 1'b0);
        add_vec(1'b1, 1'b0, 8'h03, 1'b0, 2'd3, 1'b0, 32'h44332211, 1'b0);
        add_vec(1'b1, 1'b0, 8'h04, 1'b0, 2'd0, 1'b1, 32'h04030201, 1'b0);
        add_vec(1'b1, 1'b0, 8'h05, 1'b0, 2'd1, 1'b1, 32'h04030201, 1'b0);
        add_vec(1'b1, 1'b0, 8'h06, 1'b0, 2'd2, 1'b1, 32'h04030201, 1'b0);
        add_vec(1'b1, 1'b0, 8'h07, 1'b0, 2'd3, 1'b1, 32'h04030201, 1'b0);
        add_vec(1'b1, 1'b0, 8'h08, 1'b0, 2'd0, 1'b1, 32'h04030201, 1'b1);
        add_vec(1'b1, 1'b0, 8'h09, 1'b0, 2'd1, 1'b1, 32'h04030201, 1'b1);
        add_vec(1'b1, 1'b0, 8'h0A, 1'b0, 2'd2, 1'b1, 32'h04030201, 1'b1);
        add_vec(1'b1, 1'b0, 8'h0B, 1'b0, 2'd3, 1'b1, 32'h04030201, 1'b1);
        add_vec(1'b1, 1'b0, 8'h0C, 1'b1, 2'd0, 1'b1, 32'h0C0B0A09, 1'b1);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b0, 8'hAA, 1'b0, 2'd1, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b0, 8'hBB, 1'b0, 2'd2, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b1, 8'hCC, 1'b0, 2'd0, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b0, 8'h01, 1'b0, 2'd1, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b0, 8'h02, 1'b0, 2'd2, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b0, 8'h03, 1'b0, 2'd3, 1'b0, 32'h0C0B0A09, 1'b1);
        add_vec(1'b1, 1'b0, 8'h04, 1'b0, 2'd0, 1'b1, 32'h04030201, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            i_rx_done    = vecs[i].done;
            i_rx_clear   = vecs[i].clear;
            i_rx_data    = vecs[i].data;
            i_word_ready = vecs[i].ready;
            tick();
            check($sformatf("rx vec %0d count", i), o_rx_count, vecs[i].count);
            check($sformatf("rx vec %0d valid", i), o_word_valid, vecs[i].valid);
            check($sformatf("rx vec %0d word", i), o_word, vecs[i].word);
            check($sformatf("rx vec %0d overrun", i), o_rx_overrun, vecs[i].ovr);
        end
        i_rx_done    = 1'b0;
        i_rx_clear   = 1'b0;
        i_word_ready = 1'b0;

        // TX serialize with a 10-cycle transmitter
        done_delay     = 10;
        i_tx_available = 1'b1;
        send_word(32'hDEADBEEF, acc);
        check("tx busy after accept", o_tx_busy, 1);
        check("tx ready after accept", o_tx_word_ready, 0);
        check("tx state leaves idle", (o_tx_state != idle_state), 1);
        wait_tx_idle(idle);
        check("tx pulse count", n_sig, 4);
        for (int i = 0; i < 4 && i < sig_cyc_q.size(); i++) begin
            check($sformatf("tx pulse %0d cycle", i), sig_cyc_q[i], acc + 2 + i * (10 + 2));
        end
        check("tx ready after last done", idle, acc + 2 + 3 * (10 + 2) + 10 + 1);
        check("tx result held", o_tx_result, 8'hDE);
        check_tx_bytes("tx serialize byte");

        // TX backpressure
        done_delay     = 3;
        i_tx_available = 1'b0;
        send_word(32'h01234567, acc);
        repeat (19) tick();
        check("tx no pulse while unavailable", n_sig, 0);
        i_tx_available = 1'b1;
        r = cyc;
        wait_tx_idle(idle);
        check("tx pulse after available", (sig_cyc_q.size() > 0) ? sig_cyc_q[0] : -1, r + 1);
        check("tx backpressure pulses", n_sig, 4);
        check_tx_bytes("tx backpressure byte");

        // Randomized RX and TX running together
        rst_n = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        done_delay = 0;
        fork
            rx_random();
            tx_random();
        join

        // Asynchronous reset in the middle of both paths
        done_delay     = 3;
        i_tx_available = 1'b1;
        i_rx_clear     = 1'b1;
        tick();
        i_rx_clear = 1'b0;
        feed_byte(8'h5A);
        feed_byte(8'hA5);
        check("rx partial before reset", o_rx_count, 2);
        send_word(32'h11223344, acc);
        r = -1;
        for (int k = 0; k < 200; k++) begin
            if (cap_q.size() >= 2) begin
                r = k;
                break;
            end
            tick();
        end
        check("tx second byte before reset", (r >= 0), 1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("mid-word reset");
        cap_q.delete();
        exp_q.delete();
        sig_cyc_q.delete();
        n_sig = 0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (6) tick();
        check("no resend after reset", n_sig, 0);
        send_word(32'hCAFEF00D, acc);
        wait_tx_idle(idle);
        check("tx after reset pulses", n_sig, 4);
        check_tx_bytes("tx after reset byte");
        feed_byte(8'h10);
        feed_byte(8'h20);
        feed_byte(8'h30);
        feed_byte(8'h40);
        check("rx after reset valid", o_word_valid, 1);
        check("rx after reset word", o_word, 32'h40302010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
